// File: rtl/fft_seq_multiplier_if.sv
// fft_seq_multiplier_if: request/operand/result bundle between butterfly controller and multiplier
interface fft_seq_multiplier_if #(parameter int W = 8);
    logic                MULEN;
    logic signed [W-1:0] c;
    logic signed [W-1:0] d;
    logic signed [W-1:0] product;
    logic                reg_MUL;
    logic                busy;
    logic                sat;
    modport master (output MULEN, c, d, input product, reg_MUL, busy, sat);
    modport slave  (input MULEN, c, d, output product, reg_MUL, busy, sat);
endinterface

// File: rtl/fft_seq_multiplier.sv
// fft_seq_multiplier: radix-2 Booth shift-add multiplier with rounding, saturation and post-result hold-off
module fft_seq_multiplier #(
    parameter int W       = 8,
    parameter int FRAC    = 0,
    parameter int HOLDOFF = 1
) (
    input logic clk,
    input logic rst,
    fft_seq_multiplier_if.slave bus
);
    localparam int CW = $clog2((W > HOLDOFF ? W : HOLDOFF) + 1);
    localparam logic signed [2*W:0] HALF = (2*W+1)'((1 << FRAC) >> 1);
    localparam logic signed [2*W:0] PMAX = (2*W+1)'((1 << (W-1)) - 1);
    localparam logic signed [2*W:0] PMIN = -PMAX - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, COOL} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic signed [W:0]   acc;
    logic signed [W:0]   mcand;
    logic [W-1:0]        q;
    logic                q_1;
    logic signed [W:0]   sum;
    logic signed [2*W-1:0] raw;
    logic signed [2*W:0] rnd;
    logic signed [2*W:0] scaled;
    logic                hi;
    logic                lo;
    logic [W-1:0]        res;

    always_comb begin
        sum    = (q[0] && !q_1) ? acc - mcand : (!q[0] && q_1) ? acc + mcand : acc;
        raw    = {acc[W-1:0], q};
        rnd    = {raw[2*W-1], raw} + HALF;
        scaled = rnd >>> FRAC;
        hi     = scaled > PMAX;
        lo     = scaled < PMIN;
        res    = hi ? PMAX[W-1:0] : lo ? PMIN[W-1:0] : scaled[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            q           <= '0;
            q_1         <= 1'b0;
            bus.product <= '0;
            bus.reg_MUL <= 1'b0;
            bus.busy    <= 1'b0;
            bus.sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.MULEN) begin
                    state    <= BUSY;
                    bus.busy <= 1'b1;
                    cnt      <= '0;
                    acc      <= '0;
                    mcand    <= {bus.c[W-1], bus.c};
                    q        <= bus.d;
                    q_1      <= 1'b0;
                end
                BUSY: if (!bus.MULEN) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end else if (cnt == CW'(W)) begin
                    state       <= DONE;
                    bus.product <= res;
                    bus.sat     <= hi | lo;
                    bus.reg_MUL <= 1'b1;
                end else begin
                    // arithmetic shift of {acc,q,q_1} after the add/sub
                    {acc, q, q_1} <= {sum[W], sum, q};
                    cnt           <= cnt + 1'b1;
                end
                DONE: begin
                    state       <= COOL;
                    bus.reg_MUL <= 1'b0;
                    cnt         <= '0;
                end
                COOL: if (cnt == CW'(HOLDOFF - 1)) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_seq_multiplier.sv
// tb_fft_seq_multiplier: FRAC=0 and FRAC=6 instances driven in lockstep, checked against a transaction-timeline model
module tb_fft_seq_multiplier;
    localparam int W    = 8;
    localparam int HOLD = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mulen = 1'b0;
    logic signed [7:0] c = '0;
    logic signed [7:0] d = '0;
    int vectors = 0;
    int miscompares = 0;

    fft_seq_multiplier_if #(.W(W)) i0 ();
    fft_seq_multiplier_if #(.W(W)) i1 ();
    assign i0.MULEN = mulen;
    assign i0.c = c;
    assign i0.d = d;
    assign i1.MULEN = mulen;
    assign i1.c = c;
    assign i1.d = d;

    fft_seq_multiplier #(.W(W), .FRAC(0), .HOLDOFF(HOLD)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
    fft_seq_multiplier #(.W(W), .FRAC(6), .HOLDOFF(HOLD)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

    always #5 clk = ~clk;

    function automatic logic [8:0] expect_res(int a, int b, int frac);
        longint r;
        longint cl;
        logic s;
        r = longint'(a) * longint'(b);
        if (frac > 0) r = (r + (longint'(1) << (frac - 1))) >>> frac;
        s = (r > 127) || (r < -128);
        cl = r > 127 ? 127 : r < -128 ? -128 : r;
        return {s, cl[7:0]};
    endfunction

    // since = edges elapsed since capture, -1 when idle
    int since;
    logic signed [7:0] mc, md, mp0, mp1;
    logic ms0, ms1, mstb;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            since <= -1;
            mc <= '0; md <= '0; mp0 <= '0; mp1 <= '0;
            ms0 <= 1'b0; ms1 <= 1'b0; mstb <= 1'b0;
        end else begin
            mstb <= 1'b0;
            if (since < 0) begin
                if (mulen) begin since <= 0; mc <= c; md <= d; end
            end else if (since <= W && !mulen) since <= -1;
            else if (since == W) begin
                since <= W + 1;
                mstb <= 1'b1;
                {ms0, mp0} <= expect_res(mc, md, 0);
                {ms1, mp1} <= expect_res(mc, md, 6);
            end else if (since == W + 1 + HOLD) since <= -1;
            else since <= since + 1;
        end
    end

    task automatic chk(string n, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("reg_MUL", int'(i0.reg_MUL), int'(mstb));
        chk("reg_MUL6", int'(i1.reg_MUL), int'(mstb));
        chk("busy", int'(i0.busy), int'(since >= 0));
        chk("product", int'(i0.product), int'(mp0));
        chk("sat", int'(i0.sat), int'(ms0));
        chk("product6", int'(i1.product), int'(mp1));
        chk("sat6", int'(i1.sat), int'(ms1));
    end

    task automatic wait_strobe(output int k);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (i0.reg_MUL) break;
        end
        chk("strobe_seen", int'(i0.reg_MUL), 1);
    endtask

    task automatic count_strobes(int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (i0.reg_MUL || i1.reg_MUL) cnt++;
        end
    endtask

    task automatic run_op(int a, int b, int p0, int s0, int p1, int s1);
        int k;
        @(negedge clk);
        mulen = 1'b1; c = 8'(a); d = 8'(b);
        wait_strobe(k);
        chk("latency", k, 10);
        chk("lit_product", int'(i0.product), p0);
        chk("lit_sat", int'(i0.sat), s0);
        chk("lit_product6", int'(i1.product), p1);
        chk("lit_sat6", int'(i1.sat), s1);
        mulen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int k, n;
        repeat (3) @(negedge clk);
        chk("rst_product", int'(i0.product), 0);
        chk("rst_busy", int'(i0.busy), 0);
        rst = 1'b1;
        run_op(5, -3, -15, 0, 0, 0);
        run_op(-128, -128, 127, 1, 127, 1);
        run_op(-128, 127, -128, 1, -128, 1);
        run_op(100, 50, 127, 1, 78, 0);
        run_op(45, -64, -128, 1, -45, 0);
        run_op(64, 64, 127, 1, 64, 0);
        // back-to-back with MULEN held high
        @(negedge clk);
        mulen = 1'b1; c = 8'sd7; d = 8'sd3;
        wait_strobe(k);
        chk("b2b_lat1", k, 10);
        chk("b2b_p1", int'(i0.product), 21);
        repeat (2) @(negedge clk);
        c = -8'sd2; d = 8'sd9;
        wait_strobe(k);
        chk("b2b_lat2", k, 10);
        chk("b2b_p2", int'(i0.product), -18);
        mulen = 1'b0;
        count_strobes(15, n);
        chk("b2b_no_third", n, 0);
        // abort on the 4th BUSY edge
        @(negedge clk);
        mulen = 1'b1; c = 8'sd33; d = 8'sd2;
        repeat (4) @(negedge clk);
        mulen = 1'b0;
        count_strobes(12, n);
        chk("abort_strobes", n, 0);
        chk("abort_product", int'(i0.product), -18);
        chk("abort_busy", int'(i0.busy), 0);
        run_op(33, 2, 66, 0, 1, 0);
        // asynchronous reset three edges after capture
        @(negedge clk);
        mulen = 1'b1; c = 8'sd11; d = -8'sd5;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_product", int'(i0.product), 0);
        chk("arst_busy", int'(i0.busy), 0);
        chk("arst_reg_MUL", int'(i0.reg_MUL), 0);
        chk("arst_sat", int'(i0.sat), 0);
        repeat (2) @(negedge clk);
        mulen = 1'b0;
        rst = 1'b1;
        count_strobes(15, n);
        chk("arst_no_strobe", n, 0);
        run_op(11, -5, -55, 0, -1, 0);
        // randomized bursts: operands wiggle every cycle, MULEN held for random lengths
        for (int b = 0; b < 60; b++) begin
            int hold;
            hold = $urandom_range(1, 16);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                mulen = 1'b1;
                c = ($urandom_range(0, 3) == 0) ? -8'sd128 : 8'($urandom);
                d = ($urandom_range(0, 3) == 0) ? -8'sd128 : 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                mulen = 1'b0;
            end
        end
        @(negedge clk);
        mulen = 1'b0;
        repeat (15) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
